// File: rtl/tick_counter_pkg.sv
// Shared types and default sizing for the tick-driven up counter.
package tick_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_MAX_COUNT   = 15;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/tick_counter_up_sync.sv
// tick_sync_edge: multi-flop synchronizer plus rising-edge detector for a slow
// asynchronous level (1 Hz divider output, push buttons).
module tick_sync_edge
    import tick_counter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [SYNC_STAGES:0]   r_fill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // An edge only counts between two post-reset samples, so an input already
    // high at reset release does not look like a rising edge.
    assign pulse_out = r_sync[SYNC_STAGES-1] & ~r_hist & r_fill[SYNC_STAGES];

endmodule

// File: rtl/tick_counter_up.sv
// Run/stop up counter advanced by edges of the 1 Hz divider output.
// Build option TICK_COUNTER_SATURATE_EN: stop at MAX_COUNT in a DONE state instead of wrapping.
module tick_counter_up
    import tick_counter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX_COUNT   = DEF_MAX_COUNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             run,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic             w_tick;
    logic             w_adv;
    logic             w_at_max;
    logic             w_sat_hit;
    logic [WIDTH-1:0] w_load_sat;
    logic [WIDTH-1:0] w_count_inc;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_running;

    tick_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (tick_in),
        .pulse_out (w_tick)
    );

    assign w_load_sat  = (load_val > MAX_V) ? MAX_V : load_val;
    assign w_count_inc = r_count + WIDTH'(1);
    assign w_at_max    = (r_count == MAX_V);
    assign w_adv       = w_tick && !clear && !load && (r_state == RUN);

`ifdef TICK_COUNTER_SATURATE_EN
    assign w_sat_hit = w_adv && (w_at_max || (w_count_inc == MAX_V));
`else
    assign w_sat_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_tc      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_tc <= 1'b0;

            if (clear) begin
                r_count <= '0;
            end else if (load) begin
                r_count <= w_load_sat;
            end else if (w_adv) begin
`ifdef TICK_COUNTER_SATURATE_EN
                if (w_sat_hit) begin
                    r_count <= MAX_V;
                    r_tc    <= 1'b1;
                end else begin
                    r_count <= w_count_inc;
                end
`else
                if (w_at_max) begin
                    r_count <= '0;
                    r_tc    <= 1'b1;
                end else begin
                    r_count <= w_count_inc;
                end
`endif
            end

            // running mirrors the state being entered so it stays registered
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_sat_hit) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                    end else if (!run) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                end
                DONE: begin
                    if (clear || load) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign running = r_running;

endmodule

// File: tb/tb_tick_counter_up.sv
// Scoreboard bench for tick_counter_up: two instances (MAX_COUNT 15 and 9) share stimulus.
module tb_tick_counter_up;

    localparam int SYNC = 2;

    typedef struct packed {
        logic [3:0] c0;
        logic [3:0] c1;
        logic       t0;
        logic       t1;
        logic       r0;
        logic       r1;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       tick_in;
    logic       run;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, running_a, running_b;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   tcnt   = 0;
    int   tmin   = 0;
    int   tmax   = 0;

    exp_t sb[$];
    int   smp[$];
    int   m_cnt[2];
    int   m_st[2];

    tick_counter_up #(.WIDTH(4), .MAX_COUNT(15), .SYNC_STAGES(SYNC)) dut_a (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .clear(clear),
        .load(load), .load_val(load_val), .count(count_a), .tc(tc_a), .running(running_a)
    );

    tick_counter_up #(.WIDTH(4), .MAX_COUNT(9), .SYNC_STAGES(SYNC)) dut_b (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .clear(clear),
        .load(load), .load_val(load_val), .count(count_b), .tc(tc_b), .running(running_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
    endtask

    // Reference model: state 0=idle 1=run 2=done; sample history holds -1 for "no sample since reset".
    always @(posedge clk) begin
        exp_t e;
        bit   tk;
        int   mx, c, s;
        bit   t, hit;
        bit   tcs[2];
        if (!reset) begin
            smp.delete();
            for (int k = 0; k <= SYNC; k++) smp.push_back(-1);
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_st[0]  = 0; m_st[1]  = 0;
            tcs[0]   = 0; tcs[1]   = 0;
        end else begin
            tk = (smp[SYNC-1] == 1) && (smp[SYNC] == 0);
            smp.push_front(int'(tick_in));
            void'(smp.pop_back());
            for (int i = 0; i < 2; i++) begin
                mx  = (i == 0) ? 15 : 9;
                c   = m_cnt[i];
                s   = m_st[i];
                t   = 0;
                hit = 0;
                if (clear) c = 0;
                else if (load) c = (int'(load_val) > mx) ? mx : int'(load_val);
                else if (s == 1 && tk) begin
`ifdef TICK_COUNTER_SATURATE_EN
                    if (c == mx || c + 1 == mx) begin c = mx; t = 1; hit = 1; end
                    else c = c + 1;
`else
                    if (c == mx) begin c = 0; t = 1; end
                    else c = (c + 1) % 16;
`endif
                end
                if (s == 0) s = run ? 1 : 0;
                else if (s == 1) s = hit ? 2 : (run ? 1 : 0);
                else if (clear || load) s = 0;
                m_cnt[i] = c;
                m_st[i]  = s;
                tcs[i]   = t;
            end
        end
        e.c0 = 4'(m_cnt[0]);
        e.c1 = 4'(m_cnt[1]);
        e.t0 = tcs[0];
        e.t1 = tcs[1];
        e.r0 = (m_st[0] == 1);
        e.r1 = (m_st[1] == 1);
        sb.push_back(e);
    end

    // Monitor: outputs are presented every cycle, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_underrun: got 0 entries, expected 1 at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("count_a",   int'(count_a),   int'(e.c0));
            chk("count_b",   int'(count_b),   int'(e.c1));
            chk("tc_a",      int'(tc_a),      int'(e.t0));
            chk("tc_b",      int'(tc_b),      int'(e.t1));
            chk("running_a", int'(running_a), int'(e.r0));
            chk("running_b", int'(running_b), int'(e.r1));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
        if (tmax > 0) begin
            tcnt--;
            if (tcnt <= 0) begin
                tick_in = ~tick_in;
                tcnt    = $urandom_range(tmax, tmin);
            end
        end
    endtask

    task automatic rst_now();
        reset = 1'b0;
        #1;
        chk("rst_count_a",   int'(count_a),   0);
        chk("rst_count_b",   int'(count_b),   0);
        chk("rst_running_a", int'(running_a), 0);
        chk("rst_running_b", int'(running_b), 0);
        chk("rst_tc_a",      int'(tc_a),      0);
    endtask

    initial begin
        reset = 1'b0; tick_in = 1'b0; run = 1'b0;
        clear = 1'b0; load = 1'b0; load_val = '0;
        repeat (5) cyc();

        // counting from reset with a slow square wave
        reset = 1'b1; run = 1'b1;
        tmin = 40; tmax = 40; tcnt = 40;
        repeat (300) cyc();

        // wrap / saturate run of 16+ ticks from zero
        clear = 1'b1; cyc(); clear = 1'b0;
        tmin = 3; tmax = 3; tcnt = 3;
        repeat (110) cyc();

        // hold while stopped, then resume
        run = 1'b0;
        repeat (60) cyc();
        run = 1'b1;
        repeat (40) cyc();

        // load coincident with a tick, then tick, then clear+load
        tmax = 0; tick_in = 1'b0;
        clear = 1'b1; cyc(); clear = 1'b0;
        repeat (4) cyc();
        tick_in = 1'b1; cyc(); cyc();
        load = 1'b1; load_val = 4'd9; cyc(); load = 1'b0;
        tick_in = 1'b0; repeat (3) cyc();
        tick_in = 1'b1; repeat (5) cyc();
        clear = 1'b1; load = 1'b1; load_val = 4'd5; cyc();
        clear = 1'b0; load = 1'b0;
        load = 1'b1; load_val = 4'd12; cyc(); load = 1'b0;
        tick_in = 1'b0; repeat (3) cyc();
        tick_in = 1'b1; repeat (5) cyc();

        // randomized traffic
        tmin = 1; tmax = 4; tcnt = 1;
        for (int n = 0; n < 3000; n++) begin
            clear    = ($urandom_range(49, 0) == 0);
            load     = ($urandom_range(24, 0) == 0);
            load_val = 4'($urandom_range(15, 0));
            if ($urandom_range(19, 0) == 0) run = ~run;
            if ($urandom_range(399, 0) == 0) begin
                rst_now();
                cyc();
                reset = 1'b1;
            end else begin
                cyc();
            end
        end
        clear = 1'b0; load = 1'b0; run = 1'b1;

        // reset mid-count with a tick in the synchronizer, release with tick_in high
        tmax = 0; tick_in = 1'b0;
        load = 1'b1; load_val = 4'd7; cyc(); load = 1'b0;
        repeat (4) cyc();
        tick_in = 1'b1; cyc();
        rst_now();
        repeat (3) cyc();
        reset = 1'b1;
        repeat (20) cyc();

        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
